// File: rtl/ultrasonic_ranger.sv
// ultrasonic_ranger
// Ranging controller for an HC-SR04-class ultrasonic sensor. It samples the
// 1 MHz divided clock, issues the trigger pulse, times the echo in
// microseconds, converts the echo width to centimetres by counting 58 us
// slices, and publishes one distance result per measurement cycle.
//
// Ports:
//   CLK_IN   in   system clock, all logic on posedge
//   RST_N    in   asynchronous active-low reset
//   TICK_CLK in   1 MHz divided clock, each rising edge = 1 us
//   START    in   level; a measurement begins whenever START=1 in IDLE
//   ECHO     in   sensor echo, asynchronous to CLK_IN
//   TRIG     out  sensor trigger (registered)
//   BUSY     out  high in every state except IDLE (registered)
//   DIST_CM  out  last result in cm, all ones on timeout, held between results
//   VALID    out  one-cycle pulse when DIST_CM/TIMEOUT update
//   TIMEOUT  out  1 = last result was a timeout, held with DIST_CM
module ultrasonic_ranger #(
   parameter int unsigned TRIG_US    = 10,
   parameter int unsigned TIMEOUT_US = 30000,
   parameter int unsigned PERIOD_US  = 60000,
   parameter int unsigned DIST_W     = 16
) (
   input  logic              CLK_IN,
   input  logic              RST_N,
   input  logic              TICK_CLK,
   input  logic              START,
   input  logic              ECHO,
   output logic              TRIG,
   output logic              BUSY,
   output logic [DIST_W-1:0] DIST_CM,
   output logic              VALID,
   output logic              TIMEOUT
);

   localparam int unsigned PHASE_MAX = (TIMEOUT_US > TRIG_US) ? TIMEOUT_US : TRIG_US;
   localparam int unsigned PHASE_W   = $clog2(PHASE_MAX + 1);
   localparam int unsigned PERIOD_W  = $clog2(PERIOD_US + 1);
   localparam int unsigned SUB_W     = 6;

   localparam logic [PHASE_W-1:0]  TRIG_END    = PHASE_W'(TRIG_US);
   localparam logic [PHASE_W-1:0]  TIMEOUT_END = PHASE_W'(TIMEOUT_US);
   localparam logic [PERIOD_W-1:0] PERIOD_END  = PERIOD_W'(PERIOD_US);
   // 58 us of round-trip echo per centimetre
   localparam logic [SUB_W-1:0]    SUB_LAST    = SUB_W'(57);
   localparam logic [DIST_W-1:0]   CM_SAT      = {{(DIST_W-1){1'b1}}, 1'b0};

   typedef enum logic [2:0] {
      S_IDLE,
      S_TRIG,
      S_WAIT_ECHO,
      S_MEASURE,
      S_HOLDOFF
   } state_t;

   state_t state, state_nx;

   logic tick_meta, tick_sync, tick_prev;
   logic echo_meta, echo_sync, echo_prev;
   logic tick_c, echo_rise_c, echo_fall_c;

   logic [PERIOD_W-1:0] period_cnt, period_nx;
   logic [PHASE_W-1:0]  phase_cnt, phase_nx, phase_inc_c;
   logic [SUB_W-1:0]    sub_cnt, sub_nx;
   logic [DIST_W-1:0]   cm_cnt, cm_nx;
   logic [DIST_W-1:0]   dist_nx;
   logic                timeout_nx;
   logic                valid_nx;

   // Two-flop synchronizers plus a previous-value flop for edge detection
   always_ff @(posedge CLK_IN or negedge RST_N) begin
      if (!RST_N) begin
         tick_meta <= 1'b0;
         tick_sync <= 1'b0;
         tick_prev <= 1'b0;
         echo_meta <= 1'b0;
         echo_sync <= 1'b0;
         echo_prev <= 1'b0;
      end else begin
         tick_meta <= TICK_CLK;
         tick_sync <= tick_meta;
         tick_prev <= tick_sync;
         echo_meta <= ECHO;
         echo_sync <= echo_meta;
         echo_prev <= echo_sync;
      end
   end

   assign tick_c      = tick_sync & ~tick_prev;
   assign echo_rise_c = echo_sync & ~echo_prev;
   assign echo_fall_c = ~echo_sync & echo_prev;
   assign phase_inc_c = phase_cnt + PHASE_W'(1);

   // Next-state, counter and result logic
   always_comb begin
      state_nx   = state;
      period_nx  = period_cnt;
      phase_nx   = phase_cnt;
      sub_nx     = sub_cnt;
      cm_nx      = cm_cnt;
      dist_nx    = DIST_CM;
      timeout_nx = TIMEOUT;
      valid_nx   = 1'b0;

      // Trigger-to-trigger spacing runs across every active state
      if ((state != S_IDLE) && tick_c && (period_cnt != PERIOD_END)) begin
         period_nx = period_cnt + PERIOD_W'(1);
      end

      case (state)
         S_IDLE: begin
            if (START) begin
               state_nx  = S_TRIG;
               period_nx = '0;
               phase_nx  = '0;
            end
         end

         S_TRIG: begin
            if (tick_c) begin
               phase_nx = phase_inc_c;
               if (phase_inc_c == TRIG_END) begin
                  state_nx = S_WAIT_ECHO;
                  phase_nx = '0;
               end
            end
         end

         S_WAIT_ECHO: begin
            if (tick_c) begin
               phase_nx = phase_inc_c;
            end
            // An echo already high on entry never produces a rising edge here
            if (echo_rise_c) begin
               state_nx = S_MEASURE;
               phase_nx = '0;
               sub_nx   = '0;
               cm_nx    = '0;
            end else if (tick_c && (phase_inc_c == TIMEOUT_END)) begin
               state_nx   = S_HOLDOFF;
               dist_nx    = '1;
               timeout_nx = 1'b1;
               valid_nx   = 1'b1;
            end
         end

         S_MEASURE: begin
            // A tick coinciding with the falling edge is counted before the result is taken
            if (tick_c) begin
               phase_nx = phase_inc_c;
               if (sub_cnt == SUB_LAST) begin
                  sub_nx = '0;
                  if (cm_cnt != CM_SAT) begin
                     cm_nx = cm_cnt + DIST_W'(1);
                  end
               end else begin
                  sub_nx = sub_cnt + SUB_W'(1);
               end
            end
            if (echo_fall_c) begin
               state_nx   = S_HOLDOFF;
               dist_nx    = cm_nx;
               timeout_nx = 1'b0;
               valid_nx   = 1'b1;
            end else if (tick_c && (phase_inc_c == TIMEOUT_END)) begin
               state_nx   = S_HOLDOFF;
               dist_nx    = '1;
               timeout_nx = 1'b1;
               valid_nx   = 1'b1;
            end
         end

         S_HOLDOFF: begin
            if (period_cnt == PERIOD_END) begin
               state_nx = S_IDLE;
            end
         end

         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge CLK_IN or negedge RST_N) begin
      if (!RST_N) begin
         state      <= S_IDLE;
         period_cnt <= '0;
         phase_cnt  <= '0;
         sub_cnt    <= '0;
         cm_cnt     <= '0;
      end else begin
         state      <= state_nx;
         period_cnt <= period_nx;
         phase_cnt  <= phase_nx;
         sub_cnt    <= sub_nx;
         cm_cnt     <= cm_nx;
      end
   end

   // Registered outputs, decoded from the next state so they line up with it
   always_ff @(posedge CLK_IN or negedge RST_N) begin
      if (!RST_N) begin
         TRIG    <= 1'b0;
         BUSY    <= 1'b0;
         DIST_CM <= '0;
         VALID   <= 1'b0;
         TIMEOUT <= 1'b0;
      end else begin
         TRIG    <= (state_nx == S_TRIG);
         BUSY    <= (state_nx != S_IDLE);
         DIST_CM <= dist_nx;
         VALID   <= valid_nx;
         TIMEOUT <= timeout_nx;
      end
   end

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// tb_ultrasonic_ranger
// Directed bench for ultrasonic_ranger with TRIG_US=10, TIMEOUT_US=300,
// PERIOD_US=600. TICK_CLK is a divided clock of CLK_IN, toggled just after
// a CLK_IN rising edge; echo edges are aligned to TICK_CLK rising edges so
// the number of microseconds seen by the ranger is exact.
module tb_ultrasonic_ranger;

   localparam int unsigned TRIG_US    = 10;
   localparam int unsigned TIMEOUT_US = 300;
   localparam int unsigned PERIOD_US  = 600;
   localparam int unsigned DIST_W     = 16;
   localparam int TICK_HALF = 3;
   localparam int TICK_PER  = 2 * TICK_HALF;
   localparam int W_VALID = 0;
   localparam int W_BUSY  = 1;
   localparam int W_TRIG  = 2;

   logic              CLK_IN = 1'b0;
   logic              RST_N;
   logic              TICK_CLK;
   logic              START;
   logic              ECHO;
   logic              TRIG;
   logic              BUSY;
   logic [DIST_W-1:0] DIST_CM;
   logic              VALID;
   logic              TIMEOUT;

   int n_cmp = 0;
   int n_bad = 0;
   int tick_count = 0;
   int valid_pulses = 0;
   int trig_rises = 0;
   logic trig_q = 1'b0;

   ultrasonic_ranger #(
      .TRIG_US   (TRIG_US),
      .TIMEOUT_US(TIMEOUT_US),
      .PERIOD_US (PERIOD_US),
      .DIST_W    (DIST_W)
   ) dut (
      .CLK_IN  (CLK_IN),
      .RST_N   (RST_N),
      .TICK_CLK(TICK_CLK),
      .START   (START),
      .ECHO    (ECHO),
      .TRIG    (TRIG),
      .BUSY    (BUSY),
      .DIST_CM (DIST_CM),
      .VALID   (VALID),
      .TIMEOUT (TIMEOUT)
   );

   always #5 CLK_IN = ~CLK_IN;

   initial begin
      TICK_CLK = 1'b0;
      forever begin
         repeat (TICK_HALF) @(posedge CLK_IN);
         #2 TICK_CLK = ~TICK_CLK;
      end
   end

   always @(posedge TICK_CLK) tick_count++;

   always @(negedge CLK_IN) begin
      if (VALID === 1'b1) valid_pulses++;
      if (TRIG === 1'b1 && trig_q === 1'b0) trig_rises++;
      trig_q = TRIG;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
      n_cmp++;
      assert (obs >= lo && obs <= hi) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
      end
   endtask

   // Bounded wait, sampled on the falling CLK_IN edge
   task automatic wait_sig(input int which, input logic lvl, input int max_cyc, output bit got);
      logic v;
      got = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge CLK_IN);
         case (which)
            W_VALID: v = VALID;
            W_BUSY:  v = BUSY;
            default: v = TRIG;
         endcase
         if (v === lvl) begin
            got = 1'b1;
            break;
         end
      end
   endtask

   task automatic start_pulse();
      @(negedge CLK_IN);
      START = 1'b1;
      @(negedge CLK_IN);
      START = 1'b0;
   endtask

   // Start, check the trigger, and leave the DUT waiting for its echo
   task automatic start_and_trig(input string tag);
      int t0;
      bit got;
      start_pulse();
      chk({tag, "_trig_after_start"}, TRIG, 1);
      chk({tag, "_busy_after_start"}, BUSY, 1);
      t0 = tick_count;
      wait_sig(W_TRIG, 1'b0, (TRIG_US + 5) * TICK_PER, got);
      chk({tag, "_trig_fall_seen"}, got, 1);
      chk_rng({tag, "_trig_width_ticks"}, tick_count - t0, TRIG_US - 1, TRIG_US + 1);
   endtask

   task automatic wait_idle(input string tag);
      bit got;
      wait_sig(W_BUSY, 1'b0, (PERIOD_US + 20) * TICK_PER, got);
      chk({tag, "_idle_seen"}, got, 1);
   endtask

   task automatic measure_echo(input string tag, input int w, input int exp_cm, input bit pulse_in_holdoff);
      int vp0, tr0;
      bit got;
      vp0 = valid_pulses;
      tr0 = 0;
      start_and_trig(tag);
      repeat (5) @(posedge TICK_CLK);
      ECHO = 1'b1;
      repeat (w) @(posedge TICK_CLK);
      ECHO = 1'b0;
      wait_sig(W_VALID, 1'b1, 20, got);
      chk({tag, "_valid_seen"}, got, 1);
      chk({tag, "_dist_cm"}, DIST_CM, exp_cm);
      chk({tag, "_timeout_flag"}, TIMEOUT, 0);
      @(negedge CLK_IN);
      chk({tag, "_valid_one_cycle"}, VALID, 0);
      if (pulse_in_holdoff) begin
         tr0 = trig_rises;
         start_pulse();
         chk({tag, "_busy_in_holdoff"}, BUSY, 1);
      end
      wait_idle(tag);
      repeat (10) @(negedge CLK_IN);
      chk({tag, "_valid_count"}, valid_pulses - vp0, 1);
      if (pulse_in_holdoff) begin
         chk({tag, "_no_retrigger"}, trig_rises - tr0, 0);
         chk({tag, "_stays_idle"}, BUSY, 0);
      end
   endtask

   initial begin
      int t0, r0, r1, vp0;
      bit got;

      RST_N = 1'b0;
      START = 1'b0;
      ECHO  = 1'b0;

      // Reset values
      repeat (5) @(negedge CLK_IN);
      chk("rst_trig", TRIG, 0);
      chk("rst_busy", BUSY, 0);
      RST_N = 1'b1;
      repeat (3) @(negedge CLK_IN);
      chk("post_rst_trig", TRIG, 0);
      chk("post_rst_busy", BUSY, 0);
      chk("post_rst_valid", VALID, 0);
      chk("post_rst_timeout", TIMEOUT, 0);
      chk("post_rst_dist", DIST_CM, 0);

      // 290 us -> 5 cm
      measure_echo("echo290", 290, 5, 1'b0);

      // No echo: timeout 300 ticks after the trigger falls
      start_and_trig("noecho");
      t0 = tick_count;
      wait_sig(W_VALID, 1'b1, (TIMEOUT_US + 10) * TICK_PER, got);
      chk("noecho_valid_seen", got, 1);
      chk("noecho_ticks", tick_count - t0, TIMEOUT_US);
      chk("noecho_dist", DIST_CM, 32'hFFFF);
      chk("noecho_timeout", TIMEOUT, 1);
      wait_idle("noecho");

      // 116 us -> 2 cm
      measure_echo("echo116", 116, 2, 1'b0);

      // Echo high before START: no rising edge, so the wait for echo times out
      ECHO = 1'b1;
      start_and_trig("stuckpre");
      t0 = tick_count;
      wait_sig(W_VALID, 1'b1, (TIMEOUT_US + 10) * TICK_PER, got);
      chk("stuckpre_valid_seen", got, 1);
      chk("stuckpre_ticks", tick_count - t0, TIMEOUT_US);
      chk("stuckpre_dist", DIST_CM, 32'hFFFF);
      chk("stuckpre_timeout", TIMEOUT, 1);
      ECHO = 1'b0;
      wait_idle("stuckpre");

      // 57 us -> 0 cm, with a START pulse during holdoff
      measure_echo("echo57", 57, 0, 1'b1);

      // Echo rises then stays high: timeout 300 ticks after the rise
      start_and_trig("stuckhi");
      repeat (5) @(posedge TICK_CLK);
      ECHO = 1'b1;
      @(negedge CLK_IN);
      t0 = tick_count;
      wait_sig(W_VALID, 1'b1, (TIMEOUT_US + 10) * TICK_PER, got);
      chk("stuckhi_valid_seen", got, 1);
      chk("stuckhi_ticks", tick_count - t0, TIMEOUT_US);
      chk("stuckhi_dist", DIST_CM, 32'hFFFF);
      chk("stuckhi_timeout", TIMEOUT, 1);
      ECHO = 1'b0;
      wait_idle("stuckhi");

      // Single-cycle echo glitch: either a 0 cm result or a timeout, then idle
      start_and_trig("glitch");
      repeat (5) @(posedge TICK_CLK);
      @(negedge CLK_IN);
      ECHO = 1'b1;
      @(negedge CLK_IN);
      ECHO = 1'b0;
      wait_sig(W_VALID, 1'b1, (TIMEOUT_US + 10) * TICK_PER, got);
      chk("glitch_valid_seen", got, 1);
      chk("glitch_result_ok",
          ((DIST_CM === 16'h0000 && TIMEOUT === 1'b0) ||
           (DIST_CM === 16'hFFFF && TIMEOUT === 1'b1)) ? 1 : 0, 1);
      wait_idle("glitch");
      chk("glitch_busy_low", BUSY, 0);

      // START held: consecutive trigger rises one period apart
      @(negedge CLK_IN);
      START = 1'b1;
      wait_sig(W_TRIG, 1'b1, 5, got);
      chk("rep_first_rise_seen", got, 1);
      r0 = tick_count;
      wait_sig(W_TRIG, 1'b0, (TRIG_US + 5) * TICK_PER, got);
      chk("rep_first_fall_seen", got, 1);
      wait_sig(W_TRIG, 1'b1, (PERIOD_US + 20) * TICK_PER, got);
      chk("rep_second_rise_seen", got, 1);
      r1 = tick_count;
      chk_rng("rep_period_ticks", r1 - r0, PERIOD_US - 1, PERIOD_US + 1);
      @(negedge CLK_IN);
      START = 1'b0;
      wait_idle("rep");

      // Reset in the middle of a measurement
      start_and_trig("rstmid");
      repeat (3) @(posedge TICK_CLK);
      ECHO = 1'b1;
      repeat (100) @(posedge TICK_CLK);
      @(negedge CLK_IN);
      chk("rstmid_busy_before", BUSY, 1);
      vp0 = valid_pulses;
      #2 RST_N = 1'b0;
      #1;
      chk("rstmid_trig", TRIG, 0);
      chk("rstmid_busy", BUSY, 0);
      chk("rstmid_valid", VALID, 0);
      chk("rstmid_timeout", TIMEOUT, 0);
      chk("rstmid_dist", DIST_CM, 0);
      ECHO = 1'b0;
      repeat (4) @(negedge CLK_IN);
      RST_N = 1'b1;
      repeat (20 * TICK_PER) @(negedge CLK_IN);
      chk("rstmid_no_valid", valid_pulses - vp0, 0);
      chk("rstmid_idle", BUSY, 0);
      chk("rstmid_dist_after", DIST_CM, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
